// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory stage of the pipelined LEGv8 core.
//
// Holds the EX/MEM and MEM/WB pipeline registers, runs one data-memory access
// at a time over a req/ack port, resolves the branch decision and reports bad
// or timed-out accesses.
//
// Handshake: dm_req rises when a load/store sits in EX/MEM. dm_we, dm_addr and
// dm_wdata are stable while dm_req is high. The access completes in the
// cycle dm_ack=1 (dm_rdata is sampled then). If no ack arrives within
// MAX_WAIT request cycles, the access is aborted.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   valid_E .. writeReg_E      execute-stage instruction and control bits
//   stall_M                    hold execute and earlier stages this cycle
//   PCSrc_M, PCBranch_M        taken-branch select and registered target
//   dm_req/we/addr/wdata       data-memory request
//   dm_ack, dm_rdata           data-memory completion and load data
//   err_M                      one-cycle pulse: misaligned/illegal/timed-out
//   valid_W .. result_W        writeback-stage outputs
// ---------------------------------------------------------------------------
module mem_access #(
   parameter int N        = 64,
   parameter int MAX_WAIT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         memRead_E,
   input  logic         memWrite_E,
   input  logic         regWrite_E,
   input  logic         memtoReg_E,
   input  logic         branch_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic [N-1:0] PCBranch_E,
   input  logic         zero_E,
   input  logic [4:0]   writeReg_E,
   output logic         stall_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic         err_M,
   output logic         valid_W,
   output logic         regWrite_W,
   output logic [4:0]   writeReg_W,
   output logic [N-1:0] result_W
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam int         CW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   // EX/MEM register
   logic         valid_q, memRead_q, memWrite_q, regWrite_q;
   logic         memtoReg_q, branch_q, zero_q;
   logic [N-1:0] alu_q, wdata_q, pcb_q;
   logic [4:0]   wreg_q;

   // FSM and watchdog
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;

   // MEM/WB register
   logic         valid_W_q, valid_W_d;
   logic         regWrite_W_q, regWrite_W_d;
   logic [4:0]   writeReg_W_q, writeReg_W_d;
   logic [N-1:0] result_W_q, result_W_d;

   logic mem_op_E, in_access, ack_hit, timeout, bad_M, stall;

   // The FSM enters ACCESS on the very edge that captures a good load/store,
   // so the request goes out in the first cycle the instruction is in MEM.
   assign mem_op_E  = valid_E & (memRead_E ^ memWrite_E) & (aluResult_E[2:0] == 3'b000);
   assign in_access = (state_q == ACCESS);
   assign ack_hit   = in_access & dm_ack;
   // Ack takes priority over the watchdog in the same cycle.
   assign timeout   = in_access & ~dm_ack & (wait_q == CW'(MAX_WAIT - 1));
   assign stall     = in_access & ~dm_ack & ~timeout;
   // Bad accesses never enter ACCESS, so this flags the single cycle they sit in MEM.
   assign bad_M     = valid_q & (memRead_q | memWrite_q)
                      & ((memRead_q & memWrite_q) | (alu_q[2:0] != 3'b000));

   always_comb begin
      state_d = IDLE;
      wait_d  = '0;
      if (stall) begin
         state_d = ACCESS;
         wait_d  = wait_q + CW'(1);
      end else if (mem_op_E) begin
         state_d = ACCESS;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // EX/MEM: control bits are masked so an invalid slot becomes a clean bubble.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         memRead_q  <= 1'b0;
         memWrite_q <= 1'b0;
         regWrite_q <= 1'b0;
         memtoReg_q <= 1'b0;
         branch_q   <= 1'b0;
         zero_q     <= 1'b0;
         alu_q      <= '0;
         wdata_q    <= '0;
         pcb_q      <= '0;
         wreg_q     <= '0;
      end else if (!stall) begin
         valid_q    <= valid_E;
         memRead_q  <= valid_E & memRead_E;
         memWrite_q <= valid_E & memWrite_E;
         regWrite_q <= valid_E & regWrite_E;
         memtoReg_q <= valid_E & memtoReg_E;
         branch_q   <= valid_E & branch_E;
         zero_q     <= zero_E;
         alu_q      <= aluResult_E;
         wdata_q    <= writeData_E;
         pcb_q      <= PCBranch_E;
         wreg_q     <= writeReg_E;
      end
   end

   // MEM/WB: stall and error cycles push a bubble (data fields hold) so the
   // previous instruction is written back exactly once.
   always_comb begin
      valid_W_d    = 1'b0;
      regWrite_W_d = 1'b0;
      writeReg_W_d = writeReg_W_q;
      result_W_d   = result_W_q;
      if (!stall && !timeout && !bad_M) begin
         valid_W_d    = valid_q;
         regWrite_W_d = regWrite_q;
         writeReg_W_d = wreg_q;
         result_W_d   = (ack_hit & memtoReg_q) ? dm_rdata : alu_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_W_q    <= 1'b0;
         regWrite_W_q <= 1'b0;
         writeReg_W_q <= '0;
         result_W_q   <= '0;
      end else begin
         valid_W_q    <= valid_W_d;
         regWrite_W_q <= regWrite_W_d;
         writeReg_W_q <= writeReg_W_d;
         result_W_q   <= result_W_d;
      end
   end

   assign stall_M    = stall;
   assign PCSrc_M    = valid_q & branch_q & zero_q & ~in_access;
   assign PCBranch_M = pcb_q;
   assign dm_req     = in_access;
   assign dm_we      = in_access & memWrite_q;
   assign dm_addr    = in_access ? alu_q   : '0;
   assign dm_wdata   = in_access ? wdata_q : '0;
   assign err_M      = bad_M | timeout;
   assign valid_W    = valid_W_q;
   assign regWrite_W = regWrite_W_q;
   assign writeReg_W = writeReg_W_q;
   assign result_W   = result_W_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- directed and randomized checks for mem_access.
// Inputs change 1ns after the rising edge; outputs are read after settling.
// ---------------------------------------------------------------------------
module tb_mem_access;

   localparam int N        = 64;
   localparam int MAX_WAIT = 16;
   localparam int NRAND    = 300;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         valid_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E, branch_E, zero_E;
   logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
   logic [4:0]   writeReg_E;
   logic         stall_M, PCSrc_M, dm_req, dm_we, dm_ack, err_M, valid_W, regWrite_W;
   logic [N-1:0] PCBranch_M, dm_addr, dm_wdata, dm_rdata, result_W;
   logic [4:0]   writeReg_W;

   mem_access #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E),
      .memRead_E(memRead_E), .memWrite_E(memWrite_E), .regWrite_E(regWrite_E),
      .memtoReg_E(memtoReg_E), .branch_E(branch_E),
      .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
      .zero_E(zero_E), .writeReg_E(writeReg_E),
      .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err_M(err_M),
      .valid_W(valid_W), .regWrite_W(regWrite_W), .writeReg_W(writeReg_W),
      .result_W(result_W)
   );

   // scoreboard
   int n_checks = 0;
   int n_pass   = 0;
   logic [N-1:0] exp_wb_res[$];
   logic [4:0]   exp_wb_reg[$];
   logic         exp_wb_rw[$];
   logic [N-1:0] exp_addr[$];
   logic [N-1:0] exp_wd[$];
   logic         exp_we[$];
   logic [N-1:0] exp_br[$];
   logic [N-1:0] model_mem [logic [N-1:0]];
   logic [N-1:0] resp_mem  [logic [N-1:0]];
   int err_exp   = 0;
   int err_seen  = 0;
   int resp_wait = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [N-1:0] init_val(input logic [N-1:0] a);
      return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
   endfunction

   function automatic logic [N-1:0] model_get(input logic [N-1:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_val(a);
   endfunction

   function automatic logic [N-1:0] resp_get(input logic [N-1:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic v, rd, wr, rw, m2r, br, z,
                        input logic [N-1:0] alu, wd, pcb, input logic [4:0] wreg);
      valid_E = v; memRead_E = rd; memWrite_E = wr; regWrite_E = rw;
      memtoReg_E = m2r; branch_E = br; zero_E = z;
      aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb; writeReg_E = wreg;
   endtask

   task automatic idle_e();
      set_e(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   task automatic gen_instr();
      logic [N-1:0] a, d, t;
      logic [4:0]   r;
      logic         m;
      int           kind;
      a = 64'($urandom_range(0, 31)) << 3;
      d = {$urandom, $urandom};
      t = {$urandom, $urandom};
      r = 5'($urandom_range(0, 31));
      m = 1'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
         0:       set_e(0, m, ~m, 1, 1, 1, 1, a, d, t, r);             // bubble with junk control
         1, 2:    set_e(1, 0, 0, 1'($urandom), 0, 0, 1'($urandom), d, t, a, r);
         3, 4:    set_e(1, 1, 0, 1, 1'($urandom), 0, 0, a, d, t, r);   // load
         5:       set_e(1, 0, 1, 0, 0, 0, 0, a, d, t, r);              // store
         6, 7:    set_e(1, 0, 0, 0, 0, 1, 1'($urandom), d, t, a, r);   // branch
         8:       set_e(1, m, ~m, 1, 1, 0, 0, a | 64'($urandom_range(1, 7)), d, t, r);
         default: set_e(1, 1, 1, 1, 1, 0, 0, a, d, t, r);              // illegal
      endcase
   endtask

   // Reference model: what an accepted instruction must eventually produce.
   task automatic accept();
      if (!valid_E) return;
      if ((memRead_E && memWrite_E) || ((memRead_E || memWrite_E) && aluResult_E[2:0] != 3'b000)) begin
         err_exp++;
         return;
      end
      if (memRead_E || memWrite_E) begin
         exp_we.push_back(memWrite_E);
         exp_addr.push_back(aluResult_E);
         exp_wd.push_back(writeData_E);
         if (memWrite_E) model_mem[aluResult_E] = writeData_E;
      end
      if (branch_E && zero_E) exp_br.push_back(PCBranch_E);
      exp_wb_rw.push_back(regWrite_E);
      exp_wb_reg.push_back(writeReg_E);
      exp_wb_res.push_back((memRead_E && memtoReg_E) ? model_get(aluResult_E) : aluResult_E);
   endtask

   task automatic respond();
      dm_ack   = 1'b0;
      dm_rdata = {$urandom, $urandom};
      if (dm_req) begin
         if (resp_wait < 0) resp_wait = $urandom_range(0, 4);
         if (resp_wait == 0) begin
            dm_ack   = 1'b1;
            dm_rdata = resp_get(dm_addr);
         end else begin
            resp_wait--;
         end
      end
   endtask

   task automatic observe_wb();
      if (valid_W === 1'b1) begin
         if (exp_wb_reg.size() == 0) chk("wb_unexpected", valid_W, 0);
         else begin
            chk("wb_reg", writeReg_W, exp_wb_reg.pop_front());
            chk("wb_result", result_W, exp_wb_res.pop_front());
            chk("wb_regwrite", regWrite_W, exp_wb_rw.pop_front());
         end
      end
   endtask

   task automatic observe_comb();
      chk("stall_rule", stall_M, dm_req & ~dm_ack);
      if (dm_req && dm_ack) begin
         if (exp_addr.size() == 0) chk("req_unexpected", dm_req, 0);
         else begin
            chk("req_we", dm_we, exp_we.pop_front());
            chk("req_addr", dm_addr, exp_addr.pop_front());
            chk("req_wdata", dm_wdata, exp_wd.pop_front());
         end
         if (dm_we) resp_mem[dm_addr] = dm_wdata;
         resp_wait = -1;
      end
      if (PCSrc_M === 1'b1) begin
         if (exp_br.size() == 0) chk("br_unexpected", PCSrc_M, 0);
         else chk("br_target", PCBranch_M, exp_br.pop_front());
      end
      if (err_M === 1'b1) err_seen++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit have;
      bit done;
      int n_issued;

      // reset state
      reset = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
      idle_e();
      repeat (3) tick();
      chk("rst_stall", stall_M, 0);
      chk("rst_req", dm_req, 0);
      chk("rst_valid_w", valid_W, 0);
      chk("rst_regwrite_w", regWrite_W, 0);
      chk("rst_err", err_M, 0);
      chk("rst_pcsrc", PCSrc_M, 0);
      chk("rst_result", result_W, 0);
      chk("rst_pcbranch", PCBranch_M, 0);
      reset = 1'b1;

      // pass-through ADD
      tick();
      set_e(1, 0, 0, 1, 0, 0, 0, 64'h2, '0, '0, 5'd5);
      tick(); idle_e(); #1;
      chk("pt_stall", stall_M, 0);
      chk("pt_no_req", dm_req, 0);
      tick();
      chk("pt_valid_w", valid_W, 1);
      chk("pt_wreg", writeReg_W, 5);
      chk("pt_result", result_W, 64'h2);
      chk("pt_regwrite", regWrite_W, 1);
      tick();
      chk("pt_once", valid_W, 0);

      // load with ack in the third request cycle
      set_e(1, 1, 0, 1, 1, 0, 0, 64'h100, '0, '0, 5'd7);
      tick(); idle_e();
      for (int i = 0; i < 3; i++) begin
         dm_ack   = (i == 2);
         dm_rdata = (i == 2) ? 64'hDEAD : 64'hBAD0;
         #1;
         chk("ld_req", dm_req, 1);
         chk("ld_addr", dm_addr, 64'h100);
         chk("ld_we", dm_we, 0);
         chk("ld_stall", stall_M, (i < 2));
         chk("ld_wb_pending", valid_W, 0);
         tick();
      end
      dm_ack = 1'b0; #1;
      chk("ld_valid_w", valid_W, 1);
      chk("ld_result", result_W, 64'hDEAD);
      chk("ld_wreg", writeReg_W, 7);
      chk("ld_req_off", dm_req, 0);
      tick();
      chk("ld_once", valid_W, 0);

      // store with immediate ack
      set_e(1, 0, 1, 0, 0, 0, 0, 64'h8, 64'h55, '0, 5'd3);
      tick(); idle_e(); dm_ack = 1'b1; #1;
      chk("st_req", dm_req, 1);
      chk("st_we", dm_we, 1);
      chk("st_addr", dm_addr, 64'h8);
      chk("st_wdata", dm_wdata, 64'h55);
      chk("st_stall", stall_M, 0);
      tick(); dm_ack = 1'b0; #1;
      chk("st_req_off", dm_req, 0);
      chk("st_valid_w", valid_W, 1);
      chk("st_regwrite", regWrite_W, 0);

      // branch taken, then not taken
      set_e(1, 0, 0, 0, 0, 1, 1, '0, '0, 64'h4, '0);
      tick(); idle_e(); #1;
      chk("br_pcsrc", PCSrc_M, 1);
      chk("br_target", PCBranch_M, 64'h4);
      tick();
      chk("br_once", PCSrc_M, 0);
      set_e(1, 0, 0, 0, 0, 1, 0, '0, '0, 64'h40, '0);
      tick(); idle_e(); #1;
      chk("brnt_pcsrc", PCSrc_M, 0);
      chk("brnt_target", PCBranch_M, 64'h40);
      tick();

      // misaligned load
      set_e(1, 1, 0, 1, 1, 0, 0, 64'h3, '0, '0, 5'd9);
      tick(); idle_e(); #1;
      chk("mis_req", dm_req, 0);
      chk("mis_err", err_M, 1);
      chk("mis_stall", stall_M, 0);
      tick();
      chk("mis_err_once", err_M, 0);
      chk("mis_valid_w", valid_W, 0);

      // illegal read+write
      set_e(1, 1, 1, 1, 1, 0, 0, 64'h10, '0, '0, 5'd9);
      tick(); idle_e(); #1;
      chk("ill_req", dm_req, 0);
      chk("ill_err", err_M, 1);
      tick();
      chk("ill_err_once", err_M, 0);
      chk("ill_valid_w", valid_W, 0);

      // ack never arrives: abort in the MAX_WAIT-th request cycle
      set_e(1, 1, 0, 1, 1, 0, 0, 64'h200, '0, '0, 5'd4);
      tick(); idle_e(); dm_ack = 1'b0; #1;
      for (int i = 0; i < MAX_WAIT; i++) begin
         chk("to_req", dm_req, 1);
         chk("to_err", err_M, (i == MAX_WAIT - 1));
         chk("to_stall", stall_M, (i != MAX_WAIT - 1));
         tick();
      end
      chk("to_req_off", dm_req, 0);
      chk("to_err_once", err_M, 0);
      chk("to_valid_w", valid_W, 0);
      chk("to_stall_off", stall_M, 0);

      // reset during the second request cycle; a late ack is ignored
      set_e(1, 1, 0, 1, 1, 0, 0, 64'h300, '0, '0, 5'd6);
      tick(); idle_e(); #1;
      chk("rm_req1", dm_req, 1);
      tick(); reset = 1'b0; #1;
      chk("rm_req2", dm_req, 1);
      tick(); reset = 1'b1; dm_ack = 1'b1; dm_rdata = 64'hBEEF; #1;
      chk("rm_req_off", dm_req, 0);
      chk("rm_stall", stall_M, 0);
      chk("rm_valid_w", valid_W, 0);
      tick(); dm_ack = 1'b0; #1;
      chk("rm_late_ack", valid_W, 0);
      chk("rm_err", err_M, 0);

      // randomized traffic against the reference model
      have = 0; done = 0; n_issued = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         tick();
         observe_wb();
         respond();
         if (!have) begin
            if (n_issued < NRAND) begin
               gen_instr();
               have = 1;
            end else begin
               idle_e();
            end
         end
         #1;
         observe_comb();
         if (have && !stall_M) begin
            accept();
            have = 0;
            n_issued++;
         end
         if (n_issued == NRAND && !have && exp_wb_reg.size() == 0 &&
             exp_addr.size() == 0 && !dm_req) begin
            done = 1;
            break;
         end
      end
      chk("rand_done", done, 1);
      idle_e();
      for (int i = 0; i < 3; i++) begin
         tick();
         observe_wb();
         respond();
         #1;
         observe_comb();
      end
      chk("err_count", err_seen, err_exp);
      chk("wb_left", exp_wb_reg.size(), 0);
      chk("req_left", exp_addr.size(), 0);
      chk("br_left", exp_br.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
